neuron_spike_monitor: RTL and testbench
=======================================

NEURON_SPIKE_MONITOR -- requirements
Module: neuron_spike_monitor

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: event FIFO entries; power of two, 2..16.
REQ-002 Parameter TS_W, default 16: timestamp and ISI width.
REQ-003 Parameter REFRACT, default 3: samples ignored after a detected spike.
REQ-004 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset; one clock, synchronous, active-high.
REQ-006 Port v_in, input, 8: signed membrane potential; the neuron's v[17:10].
REQ-007 Port v_valid, input, 1: v_in holds a new integration-step sample.
REQ-008 Port thresh, input, 8: signed spike threshold; software-static.
REQ-009 Port clr, input, 1: clears spike_count and ovf.
REQ-010 Port spike_pulse, output, 1: one-cycle pulse per detected spike.
REQ-011 Port evt_valid, output, 1: FIFO non-empty.
REQ-012 Port evt_ready, input, 1: consumer accepts the head event.
REQ-013 Port evt_ts, output, TS_W: timestamp of the head event.
REQ-014 Port evt_isi, output, TS_W: inter-spike interval of the head event.
REQ-015 Port spike_count, output, 8: saturating spike count.
REQ-016 Port ovf, output, 1: sticky flag; an event was dropped.

Function
REQ-017 Sample counter ts SHALL increment by 1 on each v_valid and wrap from 2^TS_W-1 to 0.
REQ-018 Spike condition (all true): v_valid=1; signed v_prev <= thresh; signed v_in > thresh; refractory counter = 0.
REQ-019 v_prev SHALL load v_in on every v_valid, spike or not.
REQ-020 On a spike, refractory counter SHALL load REFRACT; it SHALL decrement by 1 on each v_valid while nonzero.
REQ-021 spike_pulse SHALL be registered, high exactly one cycle, in the cycle after the spike sample.
REQ-022 Event ts SHALL be the ts value before that sample's increment.
REQ-023 Event ISI SHALL be (ts - last_spike_ts) mod 2^TS_W; the first spike after reset SHALL report all-ones.
REQ-024 A spike SHALL push {ts, isi} into the FIFO; push-to-evt_valid latency is 1 cycle.
REQ-025 Pop SHALL occur when evt_valid && evt_ready; evt_ts/evt_isi SHALL show the next entry in the following cycle.
REQ-026 Push while full with no pop SHALL drop the event and set ovf; last_spike_ts SHALL still update.
REQ-027 Simultaneous push and pop while full SHALL succeed with no drop.
REQ-028 Simultaneous push and pop while empty SHALL leave the FIFO holding the pushed entry, since pop is ignored when evt_valid=0.
REQ-029 spike_count SHALL increment per spike, including dropped ones, and saturate at 255.
REQ-030 clr SHALL zero spike_count and ovf; a spike in the clr cycle SHALL leave spike_count=1.
REQ-031 evt_ts/evt_isi SHALL be don't-care when evt_valid=0.

Reset
REQ-032 rst SHALL set: ts=0; v_prev=-128; refractory=0; FIFO empty; evt_valid=0; spike_pulse=0; spike_count=0; ovf=0; first-spike flag set.
REQ-033 rst SHALL discard FIFO contents, including any mid-transfer head event.

Configuration
REQ-034 Macro SPIKE_MON_ISI_EN defined: ISI SHALL be computed, stored and driven on evt_isi.
REQ-035 SPIKE_MON_ISI_EN undefined: no ISI storage or subtractor; evt_isi SHALL be tied to 0; all else unchanged.

Structure
REQ-036 Package neuron_mon_pkg SHALL hold the TS_W default, the event typedef {ts, isi} and the -128 reset constant.
REQ-037 FIFO SHALL be sub-module spike_event_fifo: synchronous, registered head, full/empty flags.

Verification
REQ-038 thresh=40; v_valid every cycle; v_in steps -70→-20→50: one spike on the 50 sample, spike_pulse 1 cycle later, evt_ts=2, evt_isi=0xFFFF.
REQ-039 Second crossing 10 samples later: evt_isi=10; crossings inside REFRACT=3 samples produce no event.
REQ-040 evt_ready=0; 5 spikes, FIFO_DEPTH=4: 4 entries retained, ovf=1, spike_count=5; clr → both 0.
REQ-041 FIFO full, spike with evt_ready=1 in the same cycle: no drop, ovf stays 0, order preserved.
REQ-042 ts preset near wrap: spike at ts=0xFFFE, next at ts=0x0003: evt_isi=5.
REQ-043 rst asserted with 2 entries queued: next cycle evt_valid=0, spike_count=0; first spike afterwards reports evt_isi=0xFFFF.

Source files
------------

// File: rtl/neuron_mon_pkg.sv
// Shared definitions for the neuron spike monitor: default timestamp width,
// the {ts, isi} event record and the membrane-potential reset constant.
package neuron_mon_pkg;

    // Default width of timestamps and inter-spike intervals
    localparam int TS_W_DEF = 16;

    // Most negative 8-bit potential; guarantees the first sample after reset
    // can be treated as a rising crossing from below
    localparam logic signed [7:0] V_RESET = 8'sh80;

    // One spike event as seen by the consumer
    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
        logic [TS_W_DEF-1:0] isi;
    } spike_evt_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous first-word-fall-through event FIFO with a registered head word.
// Storage is an array written on push; the head register is reloaded either
// from the array (after a pop) or straight from the input (push into a FIFO
// that is, or is about to become, empty).
module spike_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] head_q, head_d;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  remain;
    logic              pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign dout_o  = head_q;

    // A pop is only honoured when there is a head word; a push into a full
    // FIFO succeeds only if a pop frees a slot in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;
    assign remain  = count_q - CNT_W'(pop_ok);

    // Next occupancy and next head word
    always_comb begin
        count_d = remain + CNT_W'(push_ok);
        head_d  = head_q;
        if (push_ok && (remain == '0)) begin
            head_d = din_i;
        end else if (pop_ok) begin
            head_d = mem_q[rd_ptr_q + PTR_W'(1)];
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers, occupancy and head register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_ok);
            wr_ptr_q <= wr_ptr_q + PTR_W'(push_ok);
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/neuron_spike_monitor.sv
// Neuron spike monitor: detects upward threshold crossings of a sampled
// membrane potential, applies a refractory window, timestamps each spike and
// queues {ts, isi} events for a downstream consumer.
// Build option: define SPIKE_MON_ISI_EN to compute and queue the inter-spike
// interval; without it evt_isi is tied to zero and no ISI state exists.
module neuron_spike_monitor
    import neuron_mon_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = TS_W_DEF,
    parameter int REFRACT    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [7:0]      v_in,
    input  logic                   v_valid,
    input  logic signed [7:0]      thresh,
    input  logic                   clr,
    output logic                   spike_pulse,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [TS_W-1:0]        evt_ts,
    output logic [TS_W-1:0]        evt_isi,
    output logic [7:0]             spike_count,
    output logic                   ovf
);

    localparam int REF_W = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);

    logic [TS_W-1:0]    ts_q;
    logic signed [7:0]  v_prev_q;
    logic [REF_W-1:0]   refr_q;
    logic               spike;
    logic               spike_pulse_q;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               fifo_empty, fifo_full, fifo_drop;

    // Rising crossing from at-or-below threshold to strictly above it,
    // outside the refractory window
    assign spike = v_valid && (v_prev_q <= thresh) && (v_in > thresh)
                   && (refr_q == '0);

    // Sample timestamp, previous potential and refractory countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            v_prev_q <= V_RESET;
            refr_q   <= '0;
        end else if (v_valid) begin
            ts_q     <= ts_q + TS_W'(1);
            v_prev_q <= v_in;
            if (spike) begin
                refr_q <= REF_W'(REFRACT);
            end else if (refr_q != '0) begin
                refr_q <= refr_q - REF_W'(1);
            end
        end
    end

    // Saturating spike counter and sticky overflow; a spike or drop in the
    // clear cycle is still recorded
    always_comb begin
        count_d = clr ? 8'd0 : count_q;
        if (spike && (count_d != 8'hFF)) begin
            count_d = count_d + 8'd1;
        end
        ovf_d = (clr ? 1'b0 : ovf_q) | fifo_drop;
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_pulse_q <= 1'b0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
        end else begin
            spike_pulse_q <= spike;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
        end
    end

    assign spike_pulse = spike_pulse_q;
    assign spike_count = count_q;
    assign ovf         = ovf_q;
    assign evt_valid   = !fifo_empty;

`ifdef SPIKE_MON_ISI_EN
    localparam int DATA_W = 2 * TS_W;

    logic [TS_W-1:0]   last_ts_q;
    logic              first_q;
    logic [TS_W-1:0]   isi;
    logic [DATA_W-1:0] fifo_din, fifo_dout;

    // Interval since previous spike; all-ones until a spike has been seen
    assign isi = first_q ? '1 : (ts_q - last_ts_q);

    // Previous-spike timestamp, updated even when the event is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ts_q <= '0;
            first_q   <= 1'b1;
        end else if (spike) begin
            last_ts_q <= ts_q;
            first_q   <= 1'b0;
        end
    end

    assign fifo_din = {ts_q, isi};
    assign evt_ts   = fifo_dout[DATA_W-1:TS_W];
    assign evt_isi  = fifo_dout[TS_W-1:0];
`else
    localparam int DATA_W = TS_W;

    logic [DATA_W-1:0] fifo_din, fifo_dout;

    assign fifo_din = ts_q;
    assign evt_ts   = fifo_dout;
    assign evt_isi  = '0;
`endif

    spike_event_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (spike),
        .pop_i   (evt_ready),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop)
    );

endmodule

// File: tb/tb_neuron_spike_monitor.sv
// Directed testbench for neuron_spike_monitor (default parameters).
// Expected ISI values collapse to zero when SPIKE_MON_ISI_EN is not defined.
module tb_neuron_spike_monitor;
    import neuron_mon_pkg::*;

    localparam logic signed [7:0] LO  = -8'sd70;
    localparam logic signed [7:0] MID = -8'sd20;
    localparam logic signed [7:0] HI  = 8'sd50;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] v_in;
    logic              v_valid;
    logic signed [7:0] thresh;
    logic              clr;
    logic              spike_pulse;
    logic              evt_valid;
    logic              evt_ready;
    logic [15:0]       evt_ts;
    logic [15:0]       evt_isi;
    logic [7:0]        spike_count;
    logic              ovf;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] nts    = 16'd0;

    always #5 clk = ~clk;

    neuron_spike_monitor #(
        .FIFO_DEPTH (4),
        .TS_W       (16),
        .REFRACT    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .v_in        (v_in),
        .v_valid     (v_valid),
        .thresh      (thresh),
        .clr         (clr),
        .spike_pulse (spike_pulse),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ts      (evt_ts),
        .evt_isi     (evt_isi),
        .spike_count (spike_count),
        .ovf         (ovf)
    );

    function automatic logic [15:0] exp_isi(input logic [15:0] v);
`ifdef SPIKE_MON_ISI_EN
        return v;
`else
        return (v & 16'h0000);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic signed [7:0] v, input logic vv,
                        input logic rdy, input logic c);
        v_in      = v;
        v_valid   = vv;
        evt_ready = rdy;
        clr       = c;
        @(posedge clk);
        #1;
        if (vv && !rst) nts++;
        $display("t=%0t v_in=%0d vv=%0b rdy=%0b clr=%0b | pulse=%0b evt_valid=%0b ts=0x%0h isi=0x%0h cnt=%0d ovf=%0b",
                 $time, v, vv, rdy, c, spike_pulse, evt_valid, evt_ts, evt_isi, spike_count, ovf);
    endtask

    initial begin
        int guard;
        rst = 1'b1; thresh = 8'sd40;
        v_in = LO; v_valid = 1'b0; evt_ready = 1'b0; clr = 1'b0;
        step(LO, 0, 0, 0);
        step(LO, 0, 0, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_pulse", spike_pulse, 0);
        chk("rst_count", spike_count, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0; nts = 16'd0;

        // First crossing at ts=2
        step(LO, 1, 0, 0);
        step(MID, 1, 0, 0);
        chk("pre_spike_pulse", spike_pulse, 0);
        step(HI, 1, 0, 0);
        chk("spike1_pulse", spike_pulse, 1);
        chk("spike1_valid", evt_valid, 1);
        chk("spike1_ts", evt_ts, 2);
        chk("spike1_isi", evt_isi, exp_isi(16'hFFFF));
        chk("spike1_count", spike_count, 1);
        step(LO, 1, 1, 0);                       // ts3, pop
        chk("pulse_one_cycle", spike_pulse, 0);
        chk("pop_empty", evt_valid, 0);
        step(HI, 1, 0, 0);                       // ts4, inside refractory
        chk("refr_no_pulse", spike_pulse, 0);
        chk("refr_no_event", evt_valid, 0);
        for (int i = 0; i < 7; i++) step(LO, 1, 0, 0);   // ts5..ts11
        step(HI, 1, 0, 0);                       // ts12
        chk("spike2_ts", evt_ts, 12);
        chk("spike2_isi", evt_isi, exp_isi(16'd10));
        chk("spike2_count", spike_count, 2);
        step(LO, 1, 1, 0);                       // ts13, pop
        chk("pop2_empty", evt_valid, 0);
        step(LO, 1, 0, 1);                       // ts14, clr
        chk("clr_count", spike_count, 0);
        step(LO, 1, 0, 0);                       // ts15

        // Five spikes with no consumer: last one dropped
        for (int k = 0; k < 5; k++) begin
            step(HI, 1, 0, 0);                   // ts16+4k
            chk("ovf_pulse", spike_pulse, 1);
            chk("ovf_flag", ovf, (k == 4) ? 1 : 0);
            for (int i = 0; i < 3; i++) step(LO, 1, 0, 0);
        end
        chk("ovf_count5", spike_count, 5);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_head", evt_ts, 16);
        step(LO, 0, 0, 1);
        chk("clr2_count", spike_count, 0);
        chk("clr2_ovf", ovf, 0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", evt_valid, 1);
            chk("drain_ts", evt_ts, 32'(16 + 4 * k));
            chk("drain_isi", evt_isi, exp_isi(16'd4));
            step(LO, 0, 1, 0);
        end
        chk("drain_empty", evt_valid, 0);

        // Fill to full, then push and pop together
        for (int k = 0; k < 4; k++) begin
            step(HI, 1, 0, 0);                   // ts36+4k
            for (int i = 0; i < 3; i++) step(LO, 1, 0, 0);
        end
        chk("full_no_ovf", ovf, 0);
        step(HI, 1, 1, 0);                       // ts52 with pop
        chk("pushpop_ovf", ovf, 0);
        chk("pushpop_count", spike_count, 5);
        for (int k = 0; k < 4; k++) begin
            chk("order_valid", evt_valid, 1);
            chk("order_ts", evt_ts, 32'(40 + 4 * k));
            chk("order_isi", evt_isi, exp_isi(16'd4));
            step(LO, 0, 1, 0);
        end
        chk("order_empty", evt_valid, 0);

        // Timestamp wrap
        guard = 0;
        while (nts != 16'hFFFE && guard < 70000) begin
            step(LO, 1, 0, 0);
            guard++;
        end
        chk("wrap_reached", nts, 16'hFFFE);
        step(HI, 1, 0, 0);                       // ts 0xFFFE
        chk("wrap1_ts", evt_ts, 16'hFFFE);
        chk("wrap1_isi", evt_isi, exp_isi(16'hFFCA));
        step(LO, 1, 1, 0);                       // ts 0xFFFF, pop
        for (int i = 0; i < 3; i++) step(LO, 1, 0, 0);  // ts0..ts2
        step(HI, 1, 0, 0);                       // ts3
        chk("wrap2_ts", evt_ts, 3);
        chk("wrap2_isi", evt_isi, exp_isi(16'd5));

        // Reset with two events queued
        for (int i = 0; i < 3; i++) step(LO, 1, 0, 0);  // ts4..ts6
        step(HI, 1, 0, 0);                       // ts7
        chk("queued_valid", evt_valid, 1);
        chk("queued_head", evt_ts, 3);
        rst = 1'b1;
        step(LO, 0, 1, 0);
        chk("rst2_valid", evt_valid, 0);
        chk("rst2_count", spike_count, 0);
        chk("rst2_pulse", spike_pulse, 0);
        rst = 1'b0; nts = 16'd0;
        step(HI, 1, 0, 0);                       // ts0: from v_prev = -128
        chk("post_rst_ts", evt_ts, 0);
        chk("post_rst_isi", evt_isi, exp_isi(16'hFFFF));
        chk("post_rst_count", spike_count, 1);

        // Saturation of the spike counter
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < 3; i++) step(LO, 1, 1, 0);
            step(HI, 1, 1, 0);
        end
        chk("sat_count", spike_count, 255);
        chk("sat_ovf", ovf, 0);
        for (int i = 0; i < 3; i++) step(LO, 1, 1, 0);
        step(HI, 1, 1, 1);                       // spike in clr cycle
        chk("clr_spike_count", spike_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
